// File: rtl/pc_fetch_if.sv
// pc_fetch_if: redirect, instruction-memory and decode handshake bundle for the fetch unit
interface pc_fetch_if #(parameter int DATA_WIDTH = 32);
  logic                  redirect_en;
  logic [DATA_WIDTH-1:0] redirect_pc;
  logic                  imem_req;
  logic [DATA_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic                  if_valid;
  logic                  id_ready;
  logic [DATA_WIDTH-1:0] if_instr;
  logic [DATA_WIDTH-1:0] if_pc;
  logic [DATA_WIDTH-1:0] if_pc_next;
  logic                  misalign_exc;
  modport master (
    input  redirect_en, redirect_pc, imem_ack, imem_rdata, id_ready,
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_next, misalign_exc
  );
  modport slave (
    output redirect_en, redirect_pc, imem_ack, imem_rdata, id_ready,
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pc_next, misalign_exc
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register with PC+INC stepping, imem request FSM and decode hand-off with redirects
module pc_fetch_unit #(
  parameter int                        DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]     RESET_PC   = 32'h0040_0000,
  parameter int                        INC        = 4
) (
  input logic        clk,
  input logic        rst,
  pc_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'(INC - 1);
  state_t                state_q;
  logic [DATA_WIDTH-1:0] pc_q, pc_inc, if_instr_q, if_pc_q, if_pc_next_q;
  logic                  imem_req_q, if_valid_q, misalign_q, bad_target;
  assign pc_inc = pc_q + DATA_WIDTH'(INC);
  assign bad_target = (bus.redirect_pc & ALIGN_MASK) != '0;
  assign bus.imem_req = imem_req_q;
  assign bus.imem_addr = pc_q;
  assign bus.if_valid = if_valid_q;
  assign bus.if_instr = if_instr_q;
  assign bus.if_pc = if_pc_q;
  assign bus.if_pc_next = if_pc_next_q;
  assign bus.misalign_exc = misalign_q;
  // Redirects take priority; a misaligned target parks the unit in ERR without touching pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      imem_req_q   <= 1'b0;
      if_valid_q   <= 1'b0;
      if_instr_q   <= '0;
      if_pc_q      <= '0;
      if_pc_next_q <= '0;
      misalign_q   <= 1'b0;
    end else if (bus.redirect_en && bad_target) begin
      state_q    <= ERR;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
      misalign_q <= 1'b1;
    end else if (bus.redirect_en) begin
      state_q    <= REQ;
      pc_q       <= bus.redirect_pc;
      imem_req_q <= 1'b1;
      if_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= REQ;
          imem_req_q <= 1'b1;
        end
        REQ: if (bus.imem_ack) begin
          state_q      <= HOLD;
          imem_req_q   <= 1'b0;
          if_valid_q   <= 1'b1;
          if_instr_q   <= bus.imem_rdata;
          if_pc_q      <= pc_q;
          if_pc_next_q <= pc_inc;
        end
        HOLD: if (bus.id_ready) begin
          state_q    <= REQ;
          pc_q       <= pc_inc;
          imem_req_q <= 1'b1;
          if_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: per-cycle vector table for the fetch FSM plus wrap and throughput sequences
module tb_pc_fetch_unit;
  localparam logic [31:0] R = 32'h0040_0000;
  typedef struct {
    logic rst, re; logic [31:0] rp; logic ack; logic [31:0] rd; logic id;
    logic req; logic [31:0] addr; logic val; logic [31:0] instr, pc, nxt; logic exc;
  } vec_t;
  logic clk = 0;
  logic rst;
  int n_cmp = 0, n_fail = 0;
  vec_t vecs[$];
  pc_fetch_if #(.DATA_WIDTH(32)) bus();
  pc_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(R), .INC(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic add(input logic rs, re, input logic [31:0] rp, input logic ack,
                     input logic [31:0] rd, input logic id, input logic req,
                     input logic [31:0] addr, input logic val,
                     input logic [31:0] instr, pc, nxt, input logic exc);
    vec_t v;
    v = '{rs, re, rp, ack, rd, id, req, addr, val, instr, pc, nxt, exc};
    vecs.push_back(v);
  endtask
  task automatic drive(input logic rs, re, input logic [31:0] rp, input logic ack,
                       input logic [31:0] rd, input logic id);
    rst = rs; bus.redirect_en = re; bus.redirect_pc = rp;
    bus.imem_ack = ack; bus.imem_rdata = rd; bus.id_ready = id;
    @(posedge clk); #1;
  endtask
  initial begin
    int valids;
    // reset, then zero-wait sequential fetch
    add(1,0,0,0,0,0,           0,R,0,0,0,0,0);
    add(1,0,0,0,0,0,           0,R,0,0,0,0,0);
    add(0,0,0,1,32'h11,1,      1,R,0,0,0,0,0);
    add(0,0,0,1,32'h11,1,      0,R,1,32'h11,R,R+4,0);
    add(0,0,0,1,32'h22,1,      1,R+4,0,32'h11,R,R+4,0);
    add(0,0,0,1,32'h33,1,      0,R+4,1,32'h33,R+4,R+8,0);
    add(0,0,0,1,32'h33,1,      1,R+8,0,32'h33,R+4,R+8,0);
    // memory wait states
    add(0,0,0,0,32'hde,1,      1,R+8,0,32'h33,R+4,R+8,0);
    add(0,0,0,0,32'hde,1,      1,R+8,0,32'h33,R+4,R+8,0);
    add(0,0,0,0,32'hde,1,      1,R+8,0,32'h33,R+4,R+8,0);
    add(0,0,0,1,32'h44,1,      0,R+8,1,32'h44,R+8,R+12,0);
    // decode stall
    for (int i = 0; i < 4; i++) add(0,0,0,1,32'h55,0, 0,R+8,1,32'h44,R+8,R+12,0);
    add(0,0,0,1,32'h55,1,      1,R+12,0,32'h44,R+8,R+12,0);
    // redirect coinciding with ack
    add(0,1,32'h0040_0100,1,32'h66,1, 1,32'h0040_0100,0,32'h44,R+8,R+12,0);
    add(0,0,0,0,0,1,           1,32'h0040_0100,0,32'h44,R+8,R+12,0);
    // misaligned redirect, sticky ERR, recovery
    add(0,1,32'h0040_0102,0,0,1, 0,32'h0040_0100,0,32'h44,R+8,R+12,1);
    add(0,0,0,1,32'h77,1,      0,32'h0040_0100,0,32'h44,R+8,R+12,1);
    add(0,1,32'h0040_0200,0,0,1, 1,32'h0040_0200,0,32'h44,R+8,R+12,0);
    add(0,0,0,1,32'h88,1,      0,32'h0040_0200,1,32'h88,32'h0040_0200,32'h0040_0204,0);
    add(0,0,0,0,0,1,           1,32'h0040_0204,0,32'h88,32'h0040_0200,32'h0040_0204,0);
    // reset mid-request, then redirect while holding a word
    add(1,0,0,1,32'h99,1,      0,R,0,0,0,0,0);
    add(0,0,0,0,0,0,           1,R,0,0,0,0,0);
    add(0,0,0,1,32'h99,0,      0,R,1,32'h99,R,R+4,0);
    add(0,1,32'h0040_0300,0,0,0, 1,32'h0040_0300,0,32'h99,R,R+4,0);
    // redirect during IDLE still loads pc
    add(1,0,0,0,0,0,           0,R,0,0,0,0,0);
    add(0,1,32'h0040_0040,0,0,0, 1,32'h0040_0040,0,0,0,0,0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].re, vecs[i].rp, vecs[i].ack, vecs[i].rd, vecs[i].id);
      chk($sformatf("v%0d imem_req", i), 32'(bus.imem_req), 32'(vecs[i].req));
      chk($sformatf("v%0d imem_addr", i), bus.imem_addr, vecs[i].addr);
      chk($sformatf("v%0d if_valid", i), 32'(bus.if_valid), 32'(vecs[i].val));
      chk($sformatf("v%0d if_instr", i), bus.if_instr, vecs[i].instr);
      chk($sformatf("v%0d if_pc", i), bus.if_pc, vecs[i].pc);
      chk($sformatf("v%0d if_pc_next", i), bus.if_pc_next, vecs[i].nxt);
      chk($sformatf("v%0d misalign_exc", i), 32'(bus.misalign_exc), 32'(vecs[i].exc));
    end
    // wrap at top of address space
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    chk("wrap addr", bus.imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 1, 32'hCAFE, 0);
    chk("wrap if_pc", bus.if_pc, 32'hFFFF_FFFC);
    chk("wrap if_pc_next", bus.if_pc_next, 32'h0);
    chk("wrap if_instr", bus.if_instr, 32'hCAFE);
    drive(0, 0, 0, 0, 0, 1);
    chk("wrap next addr", bus.imem_addr, 32'h0);
    chk("wrap next req", 32'(bus.imem_req), 32'd1);
    // zero-wait throughput: one word every two cycles
    valids = 0;
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 1, 32'(i), 1);
      valids += int'(bus.if_valid);
    end
    chk("throughput valids", 32'(valids), 32'd5);
    chk("throughput addr", bus.imem_addr, 32'h14);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
